// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing monitor: recovers drawX/drawY, measures line/frame length, reports lock/errors.
// Optional frame CRC over active RGB enabled by `define VGA_SYNC_DECODER_CRC_EN.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        active_nblank,
  input  logic [7:0]  Red,
  input  logic [7:0]  Green,
  input  logic [7:0]  Blue,
  input  logic        clear_err,
  output logic [9:0]  drawX,
  output logic [9:0]  drawY,
  output logic        pix_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [11:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic [15:0] frame_crc
);

  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [11:0]   H_TOT_W = 12'(H_TOTAL);
  localparam logic [11:0]   H_ACT_W = 12'(H_ACTIVE);
  localparam logic [10:0]   V_TOT_W = 11'(V_TOTAL);
  localparam logic [10:0]   V_ACT_W = 11'(V_ACTIVE);
  localparam logic [GW-1:0] LOCK_W  = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;

  logic hs_q, vs_q, de_q, hs_p_q, vs_p_q;
  logic hs_edge, vs_edge;

  logic [11:0] pix_cnt_q, de_cnt_q, pix_inc;
  logic [10:0] line_cnt_q, act_lines_q;
  logic        skip_q, line_bad_q;
  logic        line_chk, line_err, v_bad, h_bad_frame, pix_sat, line_sat;
  logic        h_set, v_set;

  logic [9:0]  drawx_q, drawy_q;
  logic        pix_valid_q, line_start_q, frame_start_q, locked_q;
  logic        h_err_q, v_err_q;
  logic [11:0] h_meas_q;
  logic [10:0] v_meas_q;

  // Edge = stage-1 sample at the active level while the previous sample was not.
  assign hs_edge = (hs_q == SYNC_POL) && (hs_p_q != SYNC_POL);
  assign vs_edge = (vs_q == SYNC_POL) && (vs_p_q != SYNC_POL);

  assign pix_inc     = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 12'd1;
  assign line_err    = (pix_inc != H_TOT_W) || ((de_cnt_q != '0) && (de_cnt_q != H_ACT_W));
  assign line_chk    = hs_edge && !skip_q && (state_q != SEARCH);
  assign v_bad       = (line_cnt_q != V_TOT_W) || (act_lines_q != V_ACT_W);
  assign h_bad_frame = line_bad_q || (line_chk && line_err);
  assign pix_sat     = (pix_cnt_q == '1) && !hs_edge;
  assign line_sat    = (line_cnt_q == '1) && !vs_edge;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    h_set   = 1'b0;
    v_set   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (vs_edge) begin
          if (h_bad_frame || v_bad) begin
            good_d = '0;
            h_set  = h_bad_frame;
            v_set  = v_bad;
          end else begin
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == LOCK_W) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (line_chk && line_err) begin
          h_set   = 1'b1;
          state_d = MEASURE;
          good_d  = '0;
        end
        if (vs_edge && v_bad) begin
          v_set   = 1'b1;
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
    // A missing sync for a whole counter range means the link is gone, not just mistimed.
    if (pix_sat) begin
      h_set   = 1'b1;
      state_d = SEARCH;
      good_d  = '0;
    end
    if (line_sat) begin
      v_set   = 1'b1;
      state_d = SEARCH;
      good_d  = '0;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hs_q <= ~SYNC_POL;  hs_p_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;  vs_p_q <= ~SYNC_POL;
      de_q <= 1'b0;
      pix_cnt_q <= '0;  line_cnt_q <= '0;  de_cnt_q <= '0;  act_lines_q <= '0;
      skip_q <= 1'b1;  line_bad_q <= 1'b0;
      drawx_q <= '0;  drawy_q <= '0;  pix_valid_q <= 1'b0;
      line_start_q <= 1'b0;  frame_start_q <= 1'b0;  locked_q <= 1'b0;
      h_err_q <= 1'b0;  v_err_q <= 1'b0;
      h_meas_q <= '0;  v_meas_q <= '0;
    end else begin
      hs_q <= hs;  hs_p_q <= hs_q;
      vs_q <= vs;  vs_p_q <= vs_q;
      de_q <= active_nblank;

      pix_cnt_q    <= hs_edge ? 12'd0 : pix_inc;
      line_start_q <= hs_edge;
      if (hs_edge) h_meas_q <= pix_inc;

      frame_start_q <= vs_edge;
      if (vs_edge) begin
        v_meas_q   <= line_cnt_q;
        line_cnt_q <= '0;
      end else if (hs_edge && line_cnt_q != '1) begin
        line_cnt_q <= line_cnt_q + 11'd1;
      end

      if (hs_edge)                        de_cnt_q <= '0;
      else if (de_q && de_cnt_q != '1)    de_cnt_q <= de_cnt_q + 12'd1;

      if (vs_edge)                                                act_lines_q <= '0;
      else if (hs_edge && de_cnt_q != '0 && act_lines_q != '1)    act_lines_q <= act_lines_q + 11'd1;

      pix_valid_q <= de_q;
      if (de_q) begin
        drawx_q <= de_cnt_q[9:0];
        drawy_q <= act_lines_q[9:0];
      end

      // The line in progress when SEARCH exits is partial, so its hs edge is not judged.
      if (state_q == SEARCH) skip_q <= 1'b1;
      else if (hs_edge)      skip_q <= 1'b0;

      if (vs_edge)                   line_bad_q <= 1'b0;
      else if (line_chk && line_err) line_bad_q <= 1'b1;

      locked_q <= (state_q == LOCKED);
      h_err_q  <= h_set | (h_err_q & ~clear_err);
      v_err_q  <= v_set | (v_err_q & ~clear_err);
    end
  end

`ifdef VGA_SYNC_DECODER_CRC_EN
  logic [23:0] rgb_q;
  logic [15:0] crc_q, frame_crc_q;

  function automatic logic [15:0] crc_step24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      rgb_q       <= '0;
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      rgb_q <= {Red, Green, Blue};
      if (vs_edge) begin
        frame_crc_q <= crc_q;
        crc_q       <= 16'hFFFF;
      end else if (de_q) begin
        crc_q <= crc_step24(crc_q, rgb_q);
      end
    end
  end

  assign frame_crc = frame_crc_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{Red, Green, Blue};
  assign frame_crc  = '0;
`endif

  assign drawX        = drawx_q;
  assign drawY        = drawy_q;
  assign pix_valid    = pix_valid_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign h_err        = h_err_q;
  assign v_err        = v_err_q;
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;

endmodule
